serial_operand_source: RTL and testbench
========================================

# serial_operand_source

Parallel-to-serial front end for the serial adder stage. Accepts a pair of W-bit operands plus a length over a valid/ready handshake. Shifts both operands out LSB-first, one bit pair per clock, on the `vld`/`a`/`b`/`last` bus that the serial adder consumes. The downstream adder has no backpressure, so once a transfer starts it streams to completion.

## Interface
- `W`, 8: maximum operand width in bits, ≥ 2.
- `LW`, `$clog2(W)`: width of the length field.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `up_vld`  in  1  operand pair and length valid.
- `up_ready`  out  1  block can accept an operand pair this cycle.
- `up_a`  in  W  operand A, bit 0 sent first.
- `up_b`  in  W  operand B, bit 0 sent first.
- `up_len_m1`  in  LW  number of bits to send, minus 1. Range 0..W-1.
- `vld`  out  1  serial bit pair valid.
- `a`  out  1  serial bit of A.
- `b`  out  1  serial bit of B.
- `last`  out  1  final bit pair of the current transfer; only ever high together with `vld`.
- `busy`  out  1  transfer in progress; equals `vld`.

## Operation
- **FSM states:** IDLE and SHIFT.
- **Acceptance:** a transfer is accepted when `up_vld && up_ready`. This loads `sh_a <= up_a`, `sh_b <= up_b`, `len <= up_len_m1`, `cnt <= 0`, and sets the state to SHIFT.
- **In SHIFT:**
  - `vld = 1`, `a = sh_a[0]`, `b = sh_b[0]`, `last = (cnt == len)`.
  - Each cycle: shift `sh_a` and `sh_b` right by 1 with zero fill, and increment `cnt`.
- **Leaving SHIFT:** in the cycle with `last = 1`, the FSM goes to IDLE. The exception is a back-to-back load (see Configuration).
- **In IDLE:** `vld`, `a`, `b` and `last` are all 0. Data outputs are masked to 0 whenever `vld` is 0.
- **`up_len_m1 = 0`:** single-bit transfer; `vld` and `last` are high in the same single cycle.
- **Out-of-range length:** an `up_len_m1` value ≥ W is clamped to W-1.
- **`up_vld` while not ready:** ignored; the inputs are not sampled.
- **Counter wrap:** `cnt` never wraps, because the transfer ends at `cnt == len ≤ W-1`.
- **Reset:** `rst` forces IDLE and clears `sh_a`, `sh_b`, `cnt` and `len`. Reset values are `vld = 0`, `a = 0`, `b = 0`, `last = 0`, `busy = 0`.
  - `up_ready` is 0 while `rst` is high.
  - A reset in the middle of a transfer aborts it. No `last` is issued; the downstream carry is cleared by the same `rst`.

## Timing
- **`up_ready`:** combinational, `!rst && (state == IDLE)`. `SERIAL_SRC_BACK_TO_BACK_EN` extends this (see Configuration).
- **Latency:** an accept in cycle t gives the first bit pair with `vld = 1` at t+1. Bit k appears at t+1+k. `last` is at t+1+len.
- **Gap between transfers without the macro:** the next accept can happen at the earliest at t+2+len. This leaves one `vld = 0` bubble between transfers.
- **Output type:** all outputs are functions of registered state only. There is no combinational path from `up_*` to `vld`, `a`, `b` or `last`.

## Configuration
- **`SERIAL_SRC_BACK_TO_BACK_EN` defined:**
  - `up_ready = !rst && (state == IDLE || (state == SHIFT && last))`.
  - An accept during the `last` cycle reloads the registers and stays in SHIFT.
  - The next transfer's bit 0 appears the very next cycle, so `vld` stays continuously high with no bubble.
- **Not defined:** `up_ready` is high only in IDLE, and a mandatory one-cycle gap follows every `last`.

## Structure
- **Package `serial_pkg`:**
  - `SERIAL_W_DEFAULT = 8`.
  - State enum `serial_src_state_e {IDLE, SHIFT}`.
  - Length typedef `serial_len_t` (`logic [$clog2(SERIAL_W_DEFAULT)-1:0]`).
- **Sub-module `serial_piso`:** W-bit parallel-load, right-shift, zero-fill register with ports `load`, `shift`, `din[W-1:0]`, `dout`. It is instantiated twice, once for A and once for B. The FSM and counter live in the top module.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `up_vld = 1` → `vld`, `a`, `b`, `last`, `up_ready` all 0; `up_ready = 1` on the first cycle after `rst` drops.
- **Full-width transfer:** W=8, `up_a = 8'h5A`, `up_b = 8'h3C`, `up_len_m1 = 7`, accepted at t.
  - Over t+1..t+8, `a` = 0,1,0,1,1,0,1,0 and `b` = 0,0,1,1,1,1,0,0.
  - `last` is high only at t+8; `vld = 0` at t+9.
- **Short transfers:** `up_a = 8'hFF`, `up_b = 8'h01`, `up_len_m1 = 3` → 4 cycles with `a` = 1,1,1,1 and `b` = 1,0,0,0, `last` on the 4th. Then `up_len_m1 = 0` → a single cycle with `vld = last = 1`.
- **Back-to-back request:** `up_vld` held high with two transfers queued.
  - Without the macro: exactly one `vld = 0` cycle between the two `last`-terminated bursts, and `up_ready = 0` throughout SHIFT.
  - With `SERIAL_SRC_BACK_TO_BACK_EN`: no gap; `up_ready = 1` only in `last` cycles.
- **Abort:** `rst` asserted at t+3 of an 8-bit transfer → `vld = 0` at t+4 with no `last`. A new transfer accepted afterwards streams correctly from bit 0.
- **End-to-end:** the block drives a serial adder with A and B pairs (8'h5A, 8'h3C) then (8'hFF, 8'h01). The bench reassembles the serial sums, and they match 8'h96 and 8'h00 (modulo 2^8).

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial operand source and its shift registers.
package serial_pkg;

    localparam int SERIAL_W_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } serial_src_state_e;

    typedef logic [$clog2(SERIAL_W_DEFAULT)-1:0] serial_len_t;

endpackage

// File: rtl/serial_piso.sv
// W-bit parallel-in serial-out register: load wins over shift, right shift with zero fill.
// Latency: dout shows din[0] the cycle after load; no backpressure, shifts whenever told to.
module serial_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] r_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else if (load) begin
            r_sh <= din;
        end else if (shift) begin
            r_sh <= {1'b0, r_sh[W-1:1]};
        end
    end

    assign dout = r_sh[0];

endmodule

// File: rtl/serial_operand_source.sv
// Parallel-to-serial operand source for the serial adder: streams A/B LSB-first with last.
// Latency: accept at t gives bit k at t+1+k; outputs come from registered state only.
// Backpressure: up_ready only when idle (or in the last cycle with SERIAL_SRC_BACK_TO_BACK_EN).
module serial_operand_source
    import serial_pkg::*;
#(
    parameter int W  = SERIAL_W_DEFAULT,
    parameter int LW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_vld,
    output logic          up_ready,
    input  logic [W-1:0]  up_a,
    input  logic [W-1:0]  up_b,
    input  logic [LW-1:0] up_len_m1,
    output logic          vld,
    output logic          a,
    output logic          b,
    output logic          last,
    output logic          busy
);

    localparam logic [LW-1:0] LEN_MAX = LW'(W - 1);

    serial_src_state_e r_state;
    serial_src_state_e w_state_nxt;
    logic [LW-1:0]     r_cnt;
    logic [LW-1:0]     r_len;
    logic [LW-1:0]     w_len;
    logic              w_shifting;
    logic              w_last;
    logic              w_accept;
    logic              w_a_bit;
    logic              w_b_bit;

    // Non-power-of-two W leaves encodable lengths beyond the register; clamp them.
    assign w_len = ({1'b0, up_len_m1} > {1'b0, LEN_MAX}) ? LEN_MAX : up_len_m1;

    assign w_shifting = (r_state == SHIFT);
    assign w_last     = w_shifting && (r_cnt == r_len);

`ifdef SERIAL_SRC_BACK_TO_BACK_EN
    assign up_ready = !rst && (!w_shifting || w_last);
`else
    assign up_ready = !rst && !w_shifting;
`endif

    assign w_accept = up_vld && up_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (w_last)   w_state_nxt = w_accept ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_len <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_len <= w_len;
        end else if (w_shifting && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    serial_piso #(.W(W)) u_piso_a (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .shift (w_shifting),
        .din   (up_a),
        .dout  (w_a_bit)
    );

    serial_piso #(.W(W)) u_piso_b (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .shift (w_shifting),
        .din   (up_b),
        .dout  (w_b_bit)
    );

    assign vld  = w_shifting;
    assign busy = w_shifting;
    assign a    = w_shifting && w_a_bit;
    assign b    = w_shifting && w_b_bit;
    assign last = w_last;

endmodule

// File: tb/tb_serial_operand_source.sv
// Directed bench for serial_operand_source, including a serial-adder model on the output bus.
module tb_serial_operand_source;
    import serial_pkg::*;

    localparam int W  = SERIAL_W_DEFAULT;
    localparam int LW = $clog2(W);

    logic          clk;
    logic          rst;
    logic          up_vld;
    logic          up_ready;
    logic [W-1:0]  up_a;
    logic [W-1:0]  up_b;
    logic [LW-1:0] up_len_m1;
    logic          vld;
    logic          a;
    logic          b;
    logic          last;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    serial_operand_source #(.W(W), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_vld    (up_vld),
        .up_ready  (up_ready),
        .up_a      (up_a),
        .up_b      (up_b),
        .up_len_m1 (up_len_m1),
        .vld       (vld),
        .a         (a),
        .b         (b),
        .last      (last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request and wait (bounded) until it is taken; returns at the first bit's sample point.
    task automatic accept(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input serial_len_t len, input bit drop);
        int guard;
        guard     = 0;
        up_a      = a_v;
        up_b      = b_v;
        up_len_m1 = len;
        up_vld    = 1'b1;
        #1;
        while (!up_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("accept_ready", up_ready, 1);
        @(negedge clk);
        if (drop) up_vld = 1'b0;
    endtask

    task automatic burst(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input int n,
                         input bit do_sum, input logic [W-1:0] exp_sum);
        logic         c;
        logic [W-1:0] s;
        logic         rdy_exp;
        c = 1'b0;
        s = '0;
        for (int k = 0; k < n; k++) begin
`ifdef SERIAL_SRC_BACK_TO_BACK_EN
            rdy_exp = (k == n - 1);
`else
            rdy_exp = 1'b0;
`endif
            check($sformatf("vld[%0d]", k), vld, 1);
            check($sformatf("busy[%0d]", k), busy, 1);
            check($sformatf("a[%0d]", k), a, a_v[k]);
            check($sformatf("b[%0d]", k), b, b_v[k]);
            check($sformatf("last[%0d]", k), last, (k == n - 1));
            check($sformatf("rdy[%0d]", k), up_ready, rdy_exp);
            s[k] = a ^ b ^ c;
            c    = (a & b) | (c & (a ^ b));
            @(negedge clk);
        end
        if (do_sum) check("serial_sum", s, exp_sum);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        up_vld    = 1'b1;
        up_a      = 8'h5A;
        up_b      = 8'h3C;
        up_len_m1 = 3'd7;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_vld", vld, 0);
            check("rst_a", a, 0);
            check("rst_b", b, 0);
            check("rst_last", last, 0);
            check("rst_busy", busy, 0);
            check("rst_ready", up_ready, 0);
        end
        rst    = 1'b0;
        up_vld = 1'b0;
        #1;
        check("ready_after_rst", up_ready, 1);

        // Full-width transfer, 5A + 3C = 96 through the adder model
        accept(8'h5A, 8'h3C, 3'd7, 1'b1);
        burst(8'h5A, 8'h3C, 8, 1'b1, 8'h96);
        check("full_gap_vld", vld, 0);
        check("full_gap_last", last, 0);

        // Short transfers: 4 bits, then a single bit
        accept(8'hFF, 8'h01, 3'd3, 1'b1);
        burst(8'hFF, 8'h01, 4, 1'b0, 8'h00);
        check("short_gap_vld", vld, 0);
        accept(8'h00, 8'h01, 3'd0, 1'b1);
        burst(8'h00, 8'h01, 1, 1'b0, 8'h00);
        check("single_gap_vld", vld, 0);

        // Two queued transfers with up_vld held high
        accept(8'h11, 8'h22, 3'd2, 1'b0);
        up_a      = 8'h33;
        up_b      = 8'h44;
        up_len_m1 = 3'd1;
        burst(8'h11, 8'h22, 3, 1'b0, 8'h00);
`ifdef SERIAL_SRC_BACK_TO_BACK_EN
        up_vld = 1'b0;
`else
        check("b2b_bubble_vld", vld, 0);
        check("b2b_bubble_ready", up_ready, 1);
        @(negedge clk);
        up_vld = 1'b0;
`endif
        burst(8'h33, 8'h44, 2, 1'b0, 8'h00);
        check("b2b_end_vld", vld, 0);

        // Reset in the middle of an 8-bit transfer
        accept(8'h5A, 8'h3C, 3'd7, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("abort_vld[%0d]", k), vld, 1);
            check($sformatf("abort_a[%0d]", k), a, (8'h5A >> k) & 1);
            check($sformatf("abort_last[%0d]", k), last, 0);
            if (k < 2) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("abort_ready_in_rst", up_ready, 0);
        @(negedge clk);
        check("abort_vld", vld, 0);
        check("abort_last", last, 0);
        check("abort_busy", busy, 0);
        rst = 1'b0;
        accept(8'h3C, 8'h5A, 3'd7, 1'b1);
        burst(8'h3C, 8'h5A, 8, 1'b1, 8'h96);

        // End-to-end carry ripple: FF + 01 wraps to 00
        accept(8'hFF, 8'h01, 3'd7, 1'b1);
        burst(8'hFF, 8'h01, 8, 1'b1, 8'h00);
        check("final_vld", vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
